// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 = CPU load/store, port 1 = DMA/debug loader.
//
// Ports: clock, reset (async, active-low); per requester N in {0,1}:
//   reqN/readyN handshake, addrN, wdataN, word_weN, byte_weN in,
//   rvalidN/rdataN one-cycle response out.
// Memory side: mem_addr, mem_wdata, mem_word_we, mem_byte_we out,
//   mem_rdata in (combinational). busy is high whenever not IDLE.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority
//   (port 0 always wins); otherwise round-robin.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  output logic              ready0,
  output logic              ready1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              word_we0,
  input  logic              word_we1,
  input  logic              byte_we0,
  input  logic              byte_we1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_word_we,
  output logic              mem_byte_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              word_we;
    logic              byte_we;
    logic              port;
  } txn_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t state, state_nx;
  txn_t   cap, sel;
  logic [3:0] cnt;
  logic [DATA_W-1:0] rd0_q, rd1_q;
  logic gnt0, gnt1, accept;
  logic first, last;

  // Grant is only offered in IDLE, so at most one ready is ever high.
`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end
  end
`else
  logic ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      gnt0 = req0 & (~req1 | ~ptr);
      gnt1 = req1 & (~req0 | ptr);
    end
  end

  // Pointer moves to the loser; idle cycles leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= gnt0;
    end
  end
`endif

  assign accept = gnt0 | gnt1;

  always_comb begin
    sel = '{addr: addr0, wdata: wdata0,
            word_we: word_we0, byte_we: byte_we0,
            port: 1'b0};
    unique case (1'b1)
      gnt1: sel = '{addr: addr1, wdata: wdata1,
                    word_we: word_we1, byte_we: byte_we1,
                    port: 1'b1};
      default: ;
    endcase
  end

  // cnt is loaded with the latency on accept and counts down,
  // so the first cycle sees LAT and the last sees 1.
  assign first = (state == ACCESS) && (cnt == LAT);
  assign last  = (state == ACCESS) && (cnt == 4'd1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  if (last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cap <= sel;
        cnt <= LAT;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
      end
      if (last) begin
        if (cap.port) rd1_q <= mem_rdata;
        else          rd0_q <= mem_rdata;
      end
    end
  end

  assign ready0      = gnt0;
  assign ready1      = gnt1;
  assign mem_addr    = cap.addr;
  assign mem_wdata   = cap.wdata;
  // Write enables pulse once; word store takes precedence over byte.
  assign mem_word_we = first & cap.word_we;
  assign mem_byte_we = first & cap.byte_we & ~cap.word_we;
  assign rvalid0     = (state == RESP) & ~cap.port;
  assign rvalid1     = (state == RESP) & cap.port;
  assign rdata0      = rd0_q;
  assign rdata1      = rd1_q;
  assign busy        = (state != IDLE);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbiter and sequencer that shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (DMA/debug loader).
- Accepts one transaction at a time over a req/ready handshake, drives the memory for a fixed latency, then returns a one-cycle response.
- Sits between the requesters and data_mem. Its memory-side outputs connect directly to data_mem's address, write-data, word_we and byte_we inputs.

Parameters:
- ADDR_W, 32, address width on both ports and the memory side.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles the memory is held before read data is sampled (legal range 1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from port 0 / port 1.
- ready0 / ready1  out  1  handshake accept; a transfer happens when reqN && readyN.
- addr0 / addr1  in  ADDR_W  request address.
- wdata0 / wdata1  in  DATA_W  store data.
- word_we0 / word_we1  in  1  word store request.
- byte_we0 / byte_we1  in  1  byte store request.
- rvalid0 / rvalid1  out  1  one-cycle response strobe (read data or write acknowledge).
- rdata0 / rdata1  out  DATA_W  read data; valid only while rvalidN is high.
- mem_addr  out  ADDR_W  to data_mem.
- mem_wdata  out  DATA_W  to data_mem.
- mem_word_we  out  1  to data_mem.
- mem_byte_we  out  1  to data_mem.
- mem_rdata  in  DATA_W  combinational read data from data_mem.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset value of every output and register is 0: state=IDLE, priority pointer=0, captured transaction cleared.
  - Reset asserted mid-transaction aborts it immediately (asynchronously): no rvalid is issued and mem_*_we drop the same instant.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - readyN = 1 only for the granted port; at most one ready is high. Ready is a combinational function of req and the pointer.
  - Grant rule: if only one port requests, that port is granted. If both request, the port equal to the pointer is granted.
  - On accept, capture addr, wdata, word_we, byte_we and the port id; go to ACCESS; set the pointer to the non-granted port (round robin).
  - With no request: stay in IDLE and leave the pointer unchanged.
- ACCESS:
  - Lasts exactly MEM_LATENCY cycles, counted by a 4-bit down-counter.
  - mem_addr and mem_wdata are driven from the captured registers throughout.
  - mem_word_we / mem_byte_we are asserted only in the first ACCESS cycle, so each store writes exactly once.
  - If both word_we and byte_we were captured, word_we wins and mem_byte_we stays 0.
  - On the last ACCESS cycle, register mem_rdata and go to RESP.
- RESP:
  - Exactly one cycle with rvalidN = 1 for the captured port; rdataN = registered read data.
  - For stores, rdataN = memory contents sampled in the last ACCESS cycle; the bench must not rely on this value.
  - The other port's rvalid stays 0. Next state is IDLE.
- Outside ACCESS: mem_addr holds its last value, and mem_word_we = mem_byte_we = 0.
- Outside RESP: rvalidN = 0; rdataN holds its last value.
- Latency: accept at cycle T, first memory cycle T+1, rvalid at T+1+MEM_LATENCY. Peak throughput is one transaction per MEM_LATENCY+2 cycles.
- A request withdrawn before it is accepted has no effect. Input changes after acceptance are ignored.
- busy = (state != IDLE).

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN defined:
  - Port 0 always wins simultaneous requests.
  - The pointer register is removed and held at 0.
  - Port 1 is granted only when req0 = 0 in IDLE.
- Not defined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset, then store from port 0 (addr=0x10000004, wdata=0xDEADBEEF, word_we=1), then load from port 0 at the same address:
  - ready0 is high in the request cycle.
  - rvalid0 pulses at T+2 (MEM_LATENCY=1), and the load returns rdata0=0xDEADBEEF.
  - rvalid1 stays 0 throughout.
- req0 and req1 held high continuously for 8 transactions, both loads:
  - grants alternate 0,1,0,1...
  - each rvalid arrives on the correct port.
  - with DMEM_ARB_FIXED_PRIO_EN defined, only port 0 is served.
- MEM_LATENCY=3, port 1 word store:
  - mem_word_we is high for exactly 1 cycle.
  - mem_addr is stable for 3 cycles.
  - rvalid1 at T+4.
  - busy is high for 4 cycles.
- Port 0 request with word_we=1 and byte_we=1 -> mem_word_we=1 and mem_byte_we=0.
- Reset pulled low during ACCESS of a store:
  - mem_word_we falls immediately and no rvalid is issued.
  - after release, state is IDLE and pointer is 0.
  - a new port 1 load is accepted on the first cycle.
- req1 asserted, then dropped the cycle before it would be granted while port 0 is busy:
  - no port 1 transaction occurs.
  - the pointer is unchanged in idle cycles.
